turtle_clock_control: RTL and testbench
=======================================

# turtle_clock_control

Clock-enable and reset sequencer between the board-level controls and the turtle CPU subsystem. Synchronizes the `manual_clk_sw` and `pulse_clk_btn` board inputs and debounces the button. Generates the single-cycle `cpu_clk_en` strobe that advances the CPU core, plus a stretched, synchronously released `cpu_reset_n`. Supports free-running (divided) operation and manual single-step operation.

## Interface
- `DEBOUNCE_CYCLES`, default 200000: consecutive stable cycles required to accept a button level change; must be ≥1.
- `AUTO_DIV`, default 1: free-run mode asserts one enable every `AUTO_DIV` cycles; must be ≥1 (1 = every cycle).
- `RESET_HOLD_CYCLES`, default 16: cycles `cpu_reset_n` is held low after `reset` deasserts; must be ≥1.
- `clk`, input, 1: board clock; all state on its rising edge.
- `reset`, input, 1: asynchronous, active-high reset of the whole block.
- `manual_clk_sw`, input, 1: asynchronous mode select; 1 = manual step, 0 = free-run.
- `pulse_clk_btn`, input, 1: asynchronous, bouncy step button.
- `halt`, input, 1: CPU halt request. Present only with `TURTLE_CLK_HALT_EN`.
- `cpu_reset_n`, output, 1: active-low CPU reset. Registered.
- `cpu_clk_en`, output, 1: one-cycle advance strobe to the CPU. Registered.
- `step_count`, output, 16: number of `cpu_clk_en` strobes since `cpu_reset_n` rose. Registered.

## Operation
- **Reset values:** while `reset`=1, all flops clear. Outputs are `cpu_reset_n`=0, `cpu_clk_en`=0, `step_count`=0. Synchronizers, debounce counter, debounced level, edge register and divider are all 0.
- **Synchronizers:** `manual_clk_sw` and `pulse_clk_btn` each pass through 2-flop synchronizers. Only the synchronized versions are used downstream.
- **Reset stretch:**
  - A hold counter increments every cycle after `reset` falls.
  - `cpu_reset_n` goes to 1 when the counter reaches `RESET_HOLD_CYCLES`, then stays 1 until the next `reset`.
  - While `cpu_reset_n`=0, `cpu_clk_en`=0, `step_count`=0 and the divider is held at 0.
- **Debounce:**
  - The counter increments while the synchronized button differs from the debounced level.
  - The counter clears to 0 on any cycle where the two agree.
  - When the counter reaches `DEBOUNCE_CYCLES`, the debounced level takes the synchronized value and the counter clears.
  - Counter width is `$clog2(DEBOUNCE_CYCLES+1)`.
- **Free-run mode (synchronized mode = 0):**
  - The divider counts 0..`AUTO_DIV`-1 and wraps.
  - `cpu_clk_en`=1 in the cycle after the divider equals `AUTO_DIV`-1.
- **Manual mode (synchronized mode = 1):**
  - `cpu_clk_en`=1 for exactly one cycle per 0→1 transition of the debounced level.
  - A held button produces no further strobes.
  - The divider is held at 0.
- **Mode change:**
  - The edge register tracks the debounced level in both modes, so switching into manual mode while the button is held does not produce a strobe.
  - Switching into free-run mode restarts the divider from 0.
- **`step_count`:** increments by 1 on each cycle where `cpu_clk_en`=1. Wraps from 0xFFFF to 0x0000.
- **Mid-operation reset:** asserting `reset` at any time immediately clears everything, including an in-progress debounce or pending strobe. The full reset-stretch sequence repeats.

## Timing
- `cpu_reset_n` rises on the `RESET_HOLD_CYCLES`-th rising `clk` edge after `reset` falls.
- First free-run strobe: `cpu_clk_en` is high in the cycle beginning `AUTO_DIV` edges after `cpu_reset_n` rises. Subsequent strobes follow every `AUTO_DIV` cycles.
- Manual-step latency: the button is first sampled high by the synchronizer at edge E and stays stable. Then `cpu_clk_en` is high for the single cycle following edge E+`DEBOUNCE_CYCLES`+3.
- Button glitches shorter than `DEBOUNCE_CYCLES` cycles (after synchronization) produce no strobe.
- Mode-switch latency: 2 cycles (synchronizer depth) plus 1 cycle.
- `step_count` reflects a strobe on the edge that ends the strobe cycle.

## Configuration
- **`TURTLE_CLK_HALT_EN` defined:**
  - The `halt` port exists and is sampled each edge.
  - While the registered `halt`=1, free-run strobes are suppressed and the divider is held at 0.
  - Manual-mode strobes still occur, for debug stepping past a halt.
  - When `halt` returns to 0, the free-run sequence restarts from divider 0.
- **`TURTLE_CLK_HALT_EN` undefined:** the `halt` port is absent and the behaviour is identical to `halt` tied to 0.

## Test plan
- **Reset stretch:** `RESET_HOLD_CYCLES`=16, `AUTO_DIV`=1; release `reset` → `cpu_reset_n`=1 at edge 16, `cpu_clk_en`=1 every cycle after, `step_count`=10 after 10 strobes.
- **Free-run divider:** `AUTO_DIV`=4 → strobes exactly 4 cycles apart, each 1 cycle wide; 8 strobes → `step_count`=8.
- **Manual step with bounce:** `DEBOUNCE_CYCLES`=8; button toggles every 3 cycles for 20 cycles, then stays high 50 cycles → exactly one strobe, at E+11; release then repress → second strobe; `step_count`=2.
- **Mode switch while pressed:** hold button high, switch to manual → no strobe; release and press → one strobe. Switch back to free-run → divider restarts, first strobe `AUTO_DIV` cycles after mode resync.
- **Reset mid-debounce and wrap:** assert `reset` 5 cycles into a debounce → all outputs 0 immediately, no strobe after release until a fresh press. Force 65536 strobes → `step_count` wraps to 0x0000.
- **Halt (with `TURTLE_CLK_HALT_EN`):** `halt`=1 in free-run → no strobes for 100 cycles; manual press → 1 strobe; `halt`=0 → free-run resumes after `AUTO_DIV` cycles.

Source files
------------

// File: rtl/turtle_clock_control.sv
// Clock-enable / reset sequencer for the turtle CPU: input sync, button debounce, free-run divider, manual step.
// Optional halt input is compiled in when TURTLE_CLK_HALT_EN is defined.
module turtle_clock_control #(
    parameter int DEBOUNCE_CYCLES   = 200000,
    parameter int AUTO_DIV          = 1,
    parameter int RESET_HOLD_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        manual_clk_sw,
    input  logic        pulse_clk_btn,
`ifdef TURTLE_CLK_HALT_EN
    input  logic        halt,
`endif
    output logic        cpu_reset_n,
    output logic        cpu_clk_en,
    output logic [15:0] step_count
);
    localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HOLD_W = $clog2(RESET_HOLD_CYCLES + 1);
    localparam int DIV_W  = (AUTO_DIV > 1) ? $clog2(AUTO_DIV) : 1;

    localparam logic [DB_W-1:0]   DB_MAX    = DB_W'(DEBOUNCE_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_HOLD_CYCLES - 1);
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(AUTO_DIV - 1);

    logic              sw_meta, sw_sync;
    logic              btn_meta, btn_sync;
    logic              btn_level, btn_prev;
    logic [DB_W-1:0]   db_cnt;
    logic [HOLD_W-1:0] hold_cnt;
    logic [DIV_W-1:0]  div_cnt;
    logic              halt_r;
    logic              free_run;
    logic              manual_step;

`ifdef TURTLE_CLK_HALT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) halt_r <= 1'b0;
        else       halt_r <= halt;
    end
`else
    assign halt_r = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sw_meta  <= 1'b0;
            sw_sync  <= 1'b0;
            btn_meta <= 1'b0;
            btn_sync <= 1'b0;
        end else begin
            sw_meta  <= manual_clk_sw;
            sw_sync  <= sw_meta;
            btn_meta <= pulse_clk_btn;
            btn_sync <= btn_meta;
        end
    end

    // Level is accepted only after it has differed for DEBOUNCE_CYCLES edges and still differs on the next.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            db_cnt    <= '0;
            btn_level <= 1'b0;
            btn_prev  <= 1'b0;
        end else begin
            if (btn_sync == btn_level) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_MAX) begin
                btn_level <= btn_sync;
                db_cnt    <= '0;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
            btn_prev <= btn_level;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_cnt    <= '0;
            cpu_reset_n <= 1'b0;
        end else if (!cpu_reset_n) begin
            hold_cnt <= hold_cnt + 1'b1;
            if (hold_cnt == HOLD_LAST) cpu_reset_n <= 1'b1;
        end
    end

    // Edge register follows the debounced level in both modes, so entering manual mode with the button held is silent.
    assign free_run    = cpu_reset_n && !sw_sync && !halt_r;
    assign manual_step = cpu_reset_n && sw_sync && btn_level && !btn_prev;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt    <= '0;
            cpu_clk_en <= 1'b0;
            step_count <= '0;
        end else begin
            if (!free_run || div_cnt == DIV_LAST) div_cnt <= '0;
            else                                   div_cnt <= div_cnt + 1'b1;

            cpu_clk_en <= (free_run && div_cnt == DIV_LAST) || manual_step;

            if (!cpu_reset_n)    step_count <= '0;
            else if (cpu_clk_en) step_count <= step_count + 1'b1;
        end
    end
endmodule

// File: tb/tb_turtle_clock_control.sv
// Self-checking bench: event-level reference model compared every cycle, plus literal timing checks.
`timescale 1ns/1ps
module tb_turtle_clock_control;
    localparam int DB   = 8;
    localparam int DIV  = 4;
    localparam int HOLD = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1, sw = 1'b0, btn = 1'b0, halt_v = 1'b0;
    logic        rn, en;
    logic [15:0] step;
    logic        rst2 = 1'b1;
    logic        rn2, en2;
    logic [15:0] step2;

    int n_cmp = 0, n_err = 0;
    bit done = 1'b0, wrap_done = 1'b0;

    turtle_clock_control #(.DEBOUNCE_CYCLES(DB), .AUTO_DIV(DIV), .RESET_HOLD_CYCLES(HOLD)) dut (
        .clk(clk), .reset(rst), .manual_clk_sw(sw), .pulse_clk_btn(btn),
`ifdef TURTLE_CLK_HALT_EN
        .halt(halt_v),
`endif
        .cpu_reset_n(rn), .cpu_clk_en(en), .step_count(step));

    turtle_clock_control #(.DEBOUNCE_CYCLES(4), .AUTO_DIV(1), .RESET_HOLD_CYCLES(16)) dut_wrap (
        .clk(clk), .reset(rst2), .manual_clk_sw(1'b0), .pulse_clk_btn(1'b0),
`ifdef TURTLE_CLK_HALT_EN
        .halt(1'b0),
`endif
        .cpu_reset_n(rn2), .cpu_clk_en(en2), .step_count(step2));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: k counts edges since reset release; histories hold raw inputs seen at each edge.
    int          k = 0, last_hold = 0;
    bit          qb[$], qs[$], qh[$], qd[$];
    bit          exp_rn = 1'b0, exp_en = 1'b0;
    logic [15:0] exp_step = '0;

    function automatic bit seen_btn(int j);
        return (j >= 3) ? qb[j-2] : 1'b0;
    endfunction

    task automatic model_clear();
        k = 0; last_hold = 0;
        qb.delete(); qs.delete(); qh.delete(); qd.delete();
        qb.push_back(1'b0); qs.push_back(1'b0); qh.push_back(1'b0); qd.push_back(1'b0);
        exp_rn = 1'b0; exp_en = 1'b0; exp_step = '0;
    endtask

    initial begin
        model_clear();
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                model_clear();
            end else begin
                bit rel, mode, hlt, deb, flip, run, man;
                k++;
                qb.push_back(btn); qs.push_back(sw); qh.push_back(halt_v);
                rel  = (k - 1 >= HOLD);
                mode = (k >= 3) ? qs[k-2] : 1'b0;
                hlt  = (k >= 2) ? qh[k-1] : 1'b0;
                deb  = qd[k-1];
                if (k - DB >= 1) begin
                    flip = 1'b1;
                    for (int j = k - DB; j <= k; j++) if (seen_btn(j) == deb) flip = 1'b0;
                    if (flip) deb = !deb;
                end
                qd.push_back(deb);
                if (!rel) exp_step = '0;
                else if (exp_en) exp_step = exp_step + 16'd1;
                run = rel && !mode && !hlt;
                if (!run) last_hold = k;
                man = rel && mode && (k >= 2) && qd[k-1] && !qd[k-2];
                exp_en = (run && ((k - last_hold) % DIV == 0)) || man;
                exp_rn = (k >= HOLD);
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (done) break;
            chk("cpu_reset_n", rn, exp_rn);
            chk("cpu_clk_en", en, exp_en);
            chk("step_count", step, exp_step);
        end
    end

    // AUTO_DIV=1 instance: strobe every cycle from edge 17, so step_count = n-17 after edge n.
    initial begin
        repeat (2) @(posedge clk);
        #3 rst2 = 1'b0;
        for (int n = 1; n <= 65560; n++) begin
            @(posedge clk); #2;
            if (n == 15) chk("div1_rn_e15", rn2, 0);
            if (n == 16) begin chk("div1_rn_e16", rn2, 1); chk("div1_en_e16", en2, 0); end
            if (n >= 17 && n <= 40) chk("div1_en_every", en2, 1);
            if (n == 27) chk("div1_step10", step2, 10);
            if (n == 65552) chk("div1_step_ffff", step2, 16'hFFFF);
            if (n == 65553) chk("div1_step_wrap", step2, 0);
        end
        wrap_done = 1'b1;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #3;
    endtask

    task automatic count_en(input int n, output int c);
        c = 0;
        repeat (n) begin tick(1); if (en === 1'b1) c++; end
    endtask

    task automatic wait_until(input int t);
        while (k < t) tick(1);
    endtask

    initial begin
        int c, c2, e0, hold_b;
        tick(3);
        chk("reset_rn", rn, 0); chk("reset_en", en, 0); chk("reset_step", step, 0);
        rst = 1'b0;
        tick(15); chk("hold_rn_e15", rn, 0);
        tick(1);  chk("hold_rn_e16", rn, 1); chk("en_e16", en, 0);
        for (int i = 17; i < 20; i++) begin tick(1); chk("en_before_first", en, 0); end
        tick(1);  chk("first_strobe_e20", en, 1);
        tick(1);  chk("strobe_width", en, 0);
        tick(28); chk("step_after_8", step, 8);

        // manual step through a bouncy press
        sw = 1'b1; tick(6);
        c = 0;
        for (int i = 0; i < 20; i++) begin
            btn = ((i / 3) % 2 == 0); tick(1); if (en === 1'b1) c++;
        end
        count_en(50, c2); chk("bounce_one_strobe", c + c2, 1);
        btn = 1'b0; count_en(30, c); chk("release_no_strobe", c, 0);
        btn = 1'b1; e0 = k + 1;
        wait_until(e0 + 10); chk("manual_e10", en, 0);
        tick(1); chk("manual_e11", en, 1);
        tick(1); chk("manual_e12", en, 0);

        // mode switch while held, then back to free-run
        sw = 1'b0; tick(20);
        sw = 1'b1; tick(2); count_en(20, c); chk("switch_while_held", c, 0);
        btn = 1'b0; tick(15); btn = 1'b1; count_en(20, c); chk("press_after_switch", c, 1);
        sw = 1'b0; e0 = k + 1;
        wait_until(e0 + 4); chk("freerun_restart_e4", en, 0);
        tick(1); chk("freerun_restart_e5", en, 1);

        // reset in the middle of a debounce
        sw = 1'b1; btn = 1'b0; tick(20);
        btn = 1'b1; tick(5);
        rst = 1'b1; #1;
        chk("midreset_rn", rn, 0); chk("midreset_en", en, 0); chk("midreset_step", step, 0);
        tick(3); rst = 1'b0;
        count_en(60, c); chk("no_strobe_after_reset", c, 0); chk("rn_after_reset", rn, 1);
        btn = 1'b0; tick(15); btn = 1'b1; count_en(20, c); chk("fresh_press", c, 1);

`ifdef TURTLE_CLK_HALT_EN
        sw = 1'b0; halt_v = 1'b1; count_en(100, c); chk("halt_no_strobes", c, 0);
        sw = 1'b1; tick(3); btn = 1'b0; tick(15); btn = 1'b1;
        count_en(20, c); chk("halt_manual_step", c, 1);
        sw = 1'b0; halt_v = 1'b0; e0 = k + 1;
        wait_until(e0 + 4); chk("halt_resume_e4", en, 0);
        tick(1); chk("halt_resume_e5", en, 1);
`endif

        // randomized phase against the model
        hold_b = 1;
        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(0, 149) == 0) sw = ~sw;
            hold_b--;
            if (hold_b == 0) begin btn = ~btn; hold_b = $urandom_range(1, 24); end
`ifdef TURTLE_CLK_HALT_EN
            if ($urandom_range(0, 79) == 0) halt_v = ~halt_v;
`endif
            if ($urandom_range(0, 999) == 0) begin rst = 1'b1; tick(2); rst = 1'b0; end
            tick(1);
        end

        for (int g = 0; g < 70000 && !wrap_done; g++) tick(1);
        if (!wrap_done) begin
            n_cmp++; n_err++;
            $display("FAIL wrap_timeout: got 0 expected 1 (AUTO_DIV=1 run did not complete)");
        end
        done = 1'b1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
